// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings and default instruction words for the IF-stage sequencer.
package fetch_sequencer_pkg;
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
endpackage

// File: rtl/fetch_sequencer_incr.sv
// 32-bit PC incrementer; wraps modulo 2^32.
module incr (
  input  logic [31:0] a_i,
  output logic [31:0] y_o
);
  assign y_o = a_i + 32'd1;
endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: owns the PC, loads the IF/ID latch, handles stall,
// branch redirect with flush, and HALT.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instr_in,
  output logic [31:0] mem_addr,
  output logic [31:0] if_id_npc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_inc;

  incr u_incr (.a_i(pc_q), .y_o(pc_inc));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    npc_d    = npc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // Redirect beats stall: the word at the old pc is dropped.
        if (branch_taken) begin
          pc_d    = branch_target;
          instr_d = NOP_WORD;
          npc_d   = 32'd0;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = instr_in;
          npc_d   = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          cnt_d   = cnt_q + 32'd1;
          if (instr_in == HALT_WORD) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        instr_d = NOP_WORD;
        npc_d   = 32'd0;
        valid_d = 1'b0;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      npc_q    <= 32'd0;
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_addr    = pc_q;
  assign if_id_npc   = npc_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;
  assign halted      = halted_q;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against a behavioural model.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] instr_in;
  logic [31:0] mem_addr, if_id_npc, if_id_instr, fetch_count;
  logic        if_id_valid, halted;

  logic        halt_en = 1'b0;
  logic [31:0] halt_addr = 32'd0;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: phase 0=boot, 1=running, 2=halted
  int          m_phase;
  logic [31:0] m_pc, m_npc, m_instr, m_cnt;
  logic        m_valid, m_halted;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_in(instr_in), .mem_addr(mem_addr),
    .if_id_npc(if_id_npc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at a is 100+a, or the HALT word at halt_addr.
  assign instr_in = (halt_en && mem_addr == halt_addr) ? 32'hFFFF_FFFF : mem_addr + 32'd100;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (halt_en && a == halt_addr) ? 32'hFFFF_FFFF : a + 32'd100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic b, input logic [31:0] t);
    logic [31:0] w;
    if (r) begin
      m_phase = 0; m_pc = 32'd0; m_npc = 32'd0; m_instr = 32'd0;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 32'd0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 2) begin
      m_instr = 32'd0; m_valid = 1'b0; m_npc = 32'd0;
    end else if (b) begin
      m_pc = t; m_instr = 32'd0; m_valid = 1'b0; m_npc = 32'd0;
    end else if (!s) begin
      w = mem_word(m_pc);
      m_instr = w; m_npc = m_pc + 32'd1; m_valid = 1'b1;
      m_pc = m_pc + 32'd1; m_cnt = m_cnt + 32'd1;
      if (w == 32'hFFFF_FFFF) begin
        m_halted = 1'b1; m_phase = 2;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    model_step(r, s, b, t);
    @(posedge clk);
    #1;
    chk("mem_addr", mem_addr, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("fetch_count", fetch_count, m_cnt);
    if (m_phase != 2) chk("if_id_npc", if_id_npc, m_npc);
  endtask

  initial begin
    // 1: reset two cycles, boot, then sequential fetch from 0
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 32'd55);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    cycle(0, 0, 0, 0);
    chk("boot_addr", mem_addr, 32'd0);
    chk("boot_valid", {31'd0, if_id_valid}, 32'd0);
    // 2: sequential fetch
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      chk("seq_instr", if_id_instr, 32'd100 + 32'(i));
      chk("seq_npc", if_id_npc, 32'd1 + 32'(i));
      chk("seq_cnt", fetch_count, 32'd1 + 32'(i));
      chk("seq_addr", mem_addr, 32'd1 + 32'(i));
    end
    // 3: stall at pc=5
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("pre_stall_pc", mem_addr, 32'd5);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      chk("stall_pc", mem_addr, 32'd5);
      chk("stall_cnt", fetch_count, 32'd5);
      chk("stall_instr", if_id_instr, 32'd104);
    end
    cycle(0, 0, 0, 0);
    chk("post_stall_instr", if_id_instr, 32'd105);
    chk("post_stall_npc", if_id_npc, 32'd6);
    // 4: branch with stall at pc=7
    cycle(0, 0, 0, 0);
    chk("pre_br_pc", mem_addr, 32'd7);
    cycle(0, 1, 1, 32'd40);
    chk("br_pc", mem_addr, 32'd40);
    chk("br_valid", {31'd0, if_id_valid}, 32'd0);
    chk("br_instr", if_id_instr, 32'd0);
    chk("br_cnt", fetch_count, 32'd7);
    cycle(0, 0, 0, 0);
    chk("br_fetch_instr", if_id_instr, 32'd140);
    chk("br_fetch_npc", if_id_npc, 32'd41);
    // 5: wrap
    cycle(0, 0, 1, 32'hFFFF_FFFF);
    cycle(0, 0, 0, 0);
    chk("wrap_npc", if_id_npc, 32'd0);
    chk("wrap_pc", mem_addr, 32'd0);
    chk("wrap_instr", if_id_instr, 32'd99);
    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic r, s, b;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 15);
      t = $urandom_range(0, 1) ? 32'($urandom_range(0, 63)) : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      cycle(r, s, b, t);
    end
    // 6: HALT word at address 3
    halt_en = 1'b1; halt_addr = 32'd3;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    chk("pre_halt", {31'd0, halted}, 32'd0);
    cycle(0, 0, 0, 0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", mem_addr, 32'd4);
    chk("halt_instr", if_id_instr, 32'hFFFF_FFFF);
    chk("halt_valid", {31'd0, if_id_valid}, 32'd1);
    chk("halt_cnt", fetch_count, 32'd4);
    cycle(0, 0, 1, 32'd20);
    chk("halt_br_pc", mem_addr, 32'd4);
    chk("halt_br_valid", {31'd0, if_id_valid}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), 32'd9);
    chk("halt_hold_pc", mem_addr, 32'd4);
    cycle(1, 0, 0, 0);
    chk("restart_pc", mem_addr, 32'd0);
    chk("restart_halted", {31'd0, halted}, 32'd0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("restart_instr", if_id_instr, 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
